alu_cmd_sequencer: RTL and testbench

//  Command-side controller for the 8-bit combinational ALU. Accepts operation commands over a

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_cmd_sequencer.sv | 120 ++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared opcode, flag-index and FSM-state definitions for the
//             8-bit ALU and its command sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_INC = 3'b010;
    localparam logic [2:0] ALU_DEC = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b110;
    localparam logic [2:0] ALU_NOT = 3'b111;

    // Bit positions within the 4-bit {carry,zero,overflow,negative} flag word
    localparam int FLG_C = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_V = 1;
    localparam int FLG_N = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_cmd_sequencer
//  Purpose  : Handshaked command front-end for the combinational ALU with
//             accumulator chaining, N-fold iteration and sticky flags.
//  Revision : 1.0  initial release
// ============================================================================
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OP_W   = 3,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_opcode,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic              cmd_use_acc,
    input  logic [CNT_W-1:0]  cmd_repeat,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_flags,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [3:0]        rsp_flags,
    output logic [DATA_W-1:0] acc,
    output logic [3:0]        sticky_flags,
    input  logic              clr_sticky
);

    state_t              r_state;
    state_t              w_state_next;
    logic [DATA_W-1:0]   r_alu_a;
    logic [DATA_W-1:0]   r_alu_b;
    logic [OP_W-1:0]     r_alu_opcode;
    logic [DATA_W-1:0]   r_rsp_result;
    logic [3:0]          r_rsp_flags;
    logic [DATA_W-1:0]   r_acc;
    logic [3:0]          r_sticky;
    logic [CNT_W-1:0]    r_iter;
    logic                w_accept;
    logic                w_exec;
    logic                w_exec_last;
    logic [3:0]          w_sticky_base;

    assign w_accept    = (r_state == ST_IDLE) && cmd_valid;
    assign w_exec      = (r_state == ST_EXEC);
    assign w_exec_last = w_exec && (r_iter == '0);

    // A clear coinciding with an EXEC sample keeps that sample's flags
    assign w_sticky_base = clr_sticky ? 4'b0000 : r_sticky;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: if (cmd_valid)       w_state_next = ST_EXEC;
            ST_EXEC: if (r_iter == '0)    w_state_next = ST_RESP;
            ST_RESP: if (rsp_ready)       w_state_next = ST_IDLE;
            default:                      w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_opcode <= '0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
            r_acc        <= '0;
            r_sticky     <= '0;
            r_iter       <= '0;
        end else begin
            if (w_accept) begin
                r_alu_opcode <= cmd_opcode;
                r_alu_b      <= cmd_b;
                r_alu_a      <= cmd_use_acc ? r_acc : cmd_a;
                r_iter       <= cmd_repeat;
            end else if (w_exec && !w_exec_last) begin
                r_alu_a <= alu_result;
                r_iter  <= r_iter - 1'b1;
            end

            if (w_exec_last) begin
                r_rsp_result <= alu_result;
                r_rsp_flags  <= alu_flags;
                r_acc        <= alu_result;
            end

            r_sticky <= w_exec ? (w_sticky_base | alu_flags) : w_sticky_base;
        end
    end

    assign cmd_ready    = (r_state == ST_IDLE);
    assign rsp_valid    = (r_state == ST_RESP);
    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_opcode   = r_alu_opcode;
    assign rsp_result   = r_rsp_result;
    assign rsp_flags    = r_rsp_flags;
    assign acc          = r_acc;
    assign sticky_flags = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_cmd_sequencer
//  Purpose  : Directed self-checking bench pairing the sequencer with a
//             reference 8-bit ALU model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_opcode = '0;
    logic [7:0] cmd_a = '0;
    logic [7:0] cmd_b = '0;
    logic       cmd_use_acc = 1'b0;
    logic [3:0] cmd_repeat = '0;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_opcode;
    logic [7:0] alu_result;
    logic [3:0] alu_flags;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_result;
    logic [3:0] rsp_flags;
    logic [7:0] acc;
    logic [3:0] sticky_flags;
    logic       clr_sticky = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    alu_cmd_sequencer #(.DATA_W(8), .OP_W(3), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .cmd_repeat(cmd_repeat),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .acc(acc), .sticky_flags(sticky_flags),
        .clr_sticky(clr_sticky)
    );

    always #5 clk = ~clk;

    // Reference ALU: carry/borrow only for ADD/SUB, signed overflow for arithmetic ops
    logic [8:0] m_wide;
    logic       m_c, m_v;
    always_comb begin
        m_wide = '0;
        m_c    = 1'b0;
        m_v    = 1'b0;
        case (alu_opcode)
            ALU_ADD: begin
                m_wide = {1'b0, alu_a} + {1'b0, alu_b};
                m_c    = m_wide[8];
                m_v    = (alu_a[7] == alu_b[7]) && (m_wide[7] != alu_a[7]);
            end
            ALU_SUB: begin
                m_wide = {1'b0, alu_a} - {1'b0, alu_b};
                m_c    = m_wide[8];
                m_v    = (alu_a[7] != alu_b[7]) && (m_wide[7] != alu_a[7]);
            end
            ALU_INC: begin m_wide = {1'b0, alu_a + 8'd1}; m_v = (alu_a == 8'h7F); end
            ALU_DEC: begin m_wide = {1'b0, alu_a - 8'd1}; m_v = (alu_a == 8'h80); end
            ALU_AND: m_wide = {1'b0, alu_a & alu_b};
            ALU_OR:  m_wide = {1'b0, alu_a | alu_b};
            ALU_XOR: m_wide = {1'b0, alu_a ^ alu_b};
            default: m_wide = {1'b0, ~alu_a};
        endcase
    end
    assign alu_result = m_wide[7:0];
    assign alu_flags  = {m_c, (m_wide[7:0] == 8'h00), m_v, m_wide[7]};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic present(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic use_acc, input logic [3:0] rep);
        cmd_opcode  = op;
        cmd_a       = a;
        cmd_b       = b;
        cmd_use_acc = use_acc;
        cmd_repeat  = rep;
        cmd_valid   = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        int cnt;

        repeat (3) step();
        rst = 1'b0;
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_outputs", {alu_a, alu_b, alu_opcode, rsp_result, rsp_flags, acc, sticky_flags}, 0);

        // ADD 7F+01 with immediate response
        present(ALU_ADD, 8'h7F, 8'h01, 1'b0, 4'd0);
        step();
        cmd_valid = 1'b0;
        check("add_alu_a", alu_a, 8'h7F);
        check("add_rsp_valid_early", rsp_valid, 0);
        step();
        check("add_rsp_valid", rsp_valid, 1);
        check("add_result", rsp_result, 8'h80);
        check("add_flags", rsp_flags, 4'b0011);
        check("add_acc", acc, 8'h80);
        step();
        check("add_back_idle", cmd_ready, 1);

        // SUB chained from accumulator
        present(ALU_SUB, 8'h55, 8'h80, 1'b1, 4'd0);
        step();
        cmd_valid = 1'b0;
        check("sub_alu_a_acc", alu_a, 8'h80);
        step();
        check("sub_result", rsp_result, 8'h00);
        check("sub_flags", rsp_flags, 4'b0100);
        step();

        // INC FE iterated three times
        present(ALU_INC, 8'hFE, 8'h00, 1'b0, 4'd2);
        step();
        cmd_valid = 1'b0;
        check("inc_alu_a0", alu_a, 8'hFE);
        step();
        check("inc_alu_a1", alu_a, 8'hFF);
        step();
        check("inc_alu_a2", alu_a, 8'h00);
        check("inc_rsp_valid_early", rsp_valid, 0);
        step();
        check("inc_rsp_valid", rsp_valid, 1);
        check("inc_result", rsp_result, 8'h01);
        check("inc_flags", rsp_flags, 4'b0000);
        check("inc_sticky", sticky_flags, 4'b0111);
        step();

        // Backpressure: response held, queued command waits for the handshake
        rsp_ready = 1'b0;
        present(ALU_ADD, 8'h10, 8'h20, 1'b0, 4'd0);
        step();
        present(ALU_AND, 8'hF0, 8'h5A, 1'b0, 4'd0);
        step();
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_result", rsp_result, 8'h30);
            check("bp_cmd_ready", cmd_ready, 0);
            if (i < 4) step();
        end
        rsp_ready = 1'b1;
        step();
        check("bp_idle_ready", cmd_ready, 1);
        check("bp_not_accepted", alu_opcode, ALU_ADD);
        step();
        cmd_valid = 1'b0;
        check("bp_accepted_op", alu_opcode, ALU_AND);
        check("bp_accepted_a", alu_a, 8'hF0);
        step();
        check("bp_and_result", rsp_result, 8'h50);
        step();

        // Full-depth iteration: 16 INC evaluations from 00
        present(ALU_INC, 8'h00, 8'h00, 1'b0, 4'd15);
        cnt = 0;
        while (!rsp_valid && cnt < 40) begin
            step();
            cmd_valid = 1'b0;
            cnt++;
        end
        check("max_rep_latency", cnt, 17);
        check("max_rep_result", rsp_result, 8'h10);
        step();

        // Reset in the middle of a long command
        present(ALU_ADD, 8'h01, 8'h01, 1'b0, 4'd5);
        step();
        cmd_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_cmd_ready", cmd_ready, 1);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_acc_sticky", {acc, sticky_flags}, 0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rsp_valid) seen++;
        end
        check("mid_rst_no_rsp", seen, 0);

        // clr_sticky coinciding with an EXEC sample
        present(ALU_XOR, 8'h55, 8'h55, 1'b0, 4'd0);
        step();
        cmd_valid = 1'b0;
        step();
        check("xor_sticky", sticky_flags, 4'b0100);
        step();
        present(ALU_NOT, 8'h00, 8'h00, 1'b0, 4'd0);
        step();
        cmd_valid  = 1'b0;
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        check("clr_exec_sticky", sticky_flags, 4'b0001);
        check("not_result", rsp_result, 8'hFF);
        step();
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        check("clr_idle_sticky", sticky_flags, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
